ps2_keyboard_rx: RTL and testbench

//   Receives PS/2 keyboard frames and turns them into single-cycle make-code events.

---
 rtl/ps2_keyboard_rx.sv | 166 ++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ps2_keyboard_rx                                              |
// | Description : PS/2 keyboard receiver; emits single-cycle make-code events, |
// |               absorbing break (release) sequences.                         |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module ps2_keyboard_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keyboard,
  output logic       valid,
  output logic       extended,
  output logic       frame_err
);

  localparam int c_FILT_W = $clog2(FILTER_LEN + 1);
  localparam int c_TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_filt;
  logic [c_FILT_W-1:0]    r_filt_cnt;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_fall;

  state_t                 r_state, w_state_nx;
  logic [2:0]             r_bitcnt, w_bitcnt_nx;
  logic [7:0]             r_sr, w_sr_nx;
  logic                   r_par, w_par_nx;
  logic [c_TO_W-1:0]      r_to_cnt, w_to_nx;
  logic                   w_byte_ok;
  logic                   w_err;
  logic                   r_brk;
  logic                   r_ext;

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  // Strobe on the cycle the filtered clock level commits from 1 to 0.
  assign w_fall   = r_filt & ~w_clk_s & (r_filt_cnt == c_FILT_W'(FILTER_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_filt      <= 1'b1;
      r_filt_cnt  <= '0;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      if (w_clk_s == r_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_FILT_W'(FILTER_LEN - 1)) begin
        r_filt     <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + c_FILT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
      r_sr     <= '0;
      r_par    <= 1'b0;
      r_to_cnt <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_bitcnt <= w_bitcnt_nx;
      r_sr     <= w_sr_nx;
      r_par    <= w_par_nx;
      r_to_cnt <= w_to_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_bitcnt_nx = r_bitcnt;
    w_sr_nx     = r_sr;
    w_par_nx    = r_par;
    w_byte_ok   = 1'b0;
    w_err       = 1'b0;
    w_to_nx     = (r_state == S_IDLE || w_fall) ? '0 : r_to_cnt + c_TO_W'(1);
    case (r_state)
      S_IDLE: begin
        if (w_fall && !w_data_s) begin
          w_state_nx  = S_DATA;
          w_bitcnt_nx = '0;
        end
      end
      S_DATA: begin
        if (w_fall) begin
          w_sr_nx     = {w_data_s, r_sr[7:1]};
          w_bitcnt_nx = r_bitcnt + 3'd1;
          if (r_bitcnt == 3'd7) w_state_nx = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_fall) begin
          w_par_nx   = w_data_s;
          w_state_nx = S_STOP;
        end
      end
      S_STOP: begin
        if (w_fall) begin
          if (w_data_s && (^{r_sr, r_par})) w_byte_ok = 1'b1;
          else                              w_err     = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    // A stalled frame is abandoned; decoder flags are left untouched.
    if (r_state != S_IDLE && !w_fall && r_to_cnt == c_TO_W'(TIMEOUT_CYCLES - 1)) begin
      w_state_nx  = S_IDLE;
      w_err       = 1'b1;
      w_to_nx     = '0;
      w_sr_nx     = '0;
      w_bitcnt_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_brk     <= 1'b0;
      r_ext     <= 1'b0;
      keyboard  <= '0;
      extended  <= 1'b0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= w_err;
      if (w_byte_ok) begin
        case (r_sr)
          8'hE0: r_ext <= 1'b1;
          8'hF0: r_brk <= 1'b1;
          default: begin
            if (r_brk) begin
              r_brk <= 1'b0;
              r_ext <= 1'b0;
            end else begin
              keyboard <= r_sr;
              extended <= r_ext;
              valid    <= 1'b1;
              r_ext    <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ps2_keyboard_rx                                           |
// | Description : Directed self-checking bench for ps2_keyboard_rx.            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_ps2_keyboard_rx;

  localparam int HALF    = 20;
  localparam int TIMEOUT = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keyboard;
  logic       valid;
  logic       extended;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  int ecount = 0;
  int both   = 0;
  int v0, e0;
  logic [7:0] last_kb = 8'h00;
  logic       last_ext = 1'b0;

  ps2_keyboard_rx #(
    .SYNC_STAGES(2),
    .FILTER_LEN(4),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .keyboard(keyboard),
    .valid(valid),
    .extended(extended),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid) begin
      vcount++;
      last_kb  = keyboard;
      last_ext = extended;
    end
    if (frame_err) ecount++;
    if (valid && frame_err) both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Optional 1-cycle glitches in both the high and low phases of the bit.
  task automatic send_bit(input logic b, input logic glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cycles(HALF/2); ps2_clk = 1'b0; wait_cycles(1); ps2_clk = 1'b1;
      wait_cycles(HALF/2 - 1); ps2_clk = 1'b0;
      wait_cycles(HALF/2); ps2_clk = 1'b1; wait_cycles(1); ps2_clk = 1'b0;
      wait_cycles(HALF/2 - 1); ps2_clk = 1'b1;
    end else begin
      wait_cycles(HALF); ps2_clk = 1'b0;
      wait_cycles(HALF); ps2_clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop_val, input logic glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit((~^b) ^ par_flip, glitch);
    send_bit(stop_val, glitch);
    ps2_data = 1'b1;
    wait_cycles(30);
  endtask

  task automatic snap();
    v0 = vcount;
    e0 = ecount;
  endtask

  initial begin
    wait_cycles(3);
    check("reset_keyboard", 32'(keyboard), 32'h00);
    check("reset_extended", 32'(extended), 32'h0);
    check("reset_valid", 32'(valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);
    rst = 1'b1;
    wait_cycles(10);

    snap(); send_frame(8'h1D, 1'b0, 1'b1, 1'b0);
    check("1D_valid_count", 32'(vcount - v0), 32'd1);
    check("1D_keyboard", 32'(last_kb), 32'h1D);
    check("1D_extended", 32'(last_ext), 32'h0);
    check("1D_no_err", 32'(ecount - e0), 32'd0);

    snap(); send_frame(8'hF0, 1'b0, 1'b1, 1'b0); send_frame(8'h1D, 1'b0, 1'b1, 1'b0);
    check("break_no_valid", 32'(vcount - v0), 32'd0);
    check("break_no_err", 32'(ecount - e0), 32'd0);
    snap(); send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check("29_valid_count", 32'(vcount - v0), 32'd1);
    check("29_keyboard_held", 32'(keyboard), 32'h29);

    snap(); send_frame(8'hE0, 1'b0, 1'b1, 1'b0); send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check("E075_valid_count", 32'(vcount - v0), 32'd1);
    check("E075_keyboard", 32'(last_kb), 32'h75);
    check("E075_extended", 32'(last_ext), 32'h1);
    snap();
    send_frame(8'hE0, 1'b0, 1'b1, 1'b0); send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check("ext_break_no_valid", 32'(vcount - v0), 32'd0);
    snap(); send_frame(8'h1B, 1'b0, 1'b1, 1'b0);
    check("1B_keyboard", 32'(last_kb), 32'h1B);
    check("1B_extended_cleared", 32'(last_ext), 32'h0);

    snap(); send_frame(8'h1B, 1'b1, 1'b1, 1'b0);
    check("parity_err_pulse", 32'(ecount - e0), 32'd1);
    check("parity_no_valid", 32'(vcount - v0), 32'd0);
    check("parity_keyboard_held", 32'(keyboard), 32'h1B);
    snap(); send_frame(8'h1B, 1'b0, 1'b1, 1'b0);
    check("typematic_1B_valid", 32'(vcount - v0), 32'd1);
    check("typematic_1B_keyboard", 32'(last_kb), 32'h1B);

    snap();
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    wait_cycles(TIMEOUT + 100);
    check("timeout_err_pulse", 32'(ecount - e0), 32'd1);
    check("timeout_no_valid", 32'(vcount - v0), 32'd0);
    snap(); send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check("after_timeout_valid", 32'(vcount - v0), 32'd1);
    check("after_timeout_keyboard", 32'(last_kb), 32'h29);

    snap(); send_frame(8'h1D, 1'b0, 1'b1, 1'b1);
    check("glitch_valid_count", 32'(vcount - v0), 32'd1);
    check("glitch_keyboard", 32'(last_kb), 32'h1D);
    check("glitch_no_err", 32'(ecount - e0), 32'd0);

    snap(); send_frame(8'h29, 1'b0, 1'b0, 1'b0);
    check("stop_err_pulse", 32'(ecount - e0), 32'd1);
    check("stop_no_valid", 32'(vcount - v0), 32'd0);

    send_frame(8'hE0, 1'b0, 1'b1, 1'b0); send_frame(8'h75, 1'b0, 1'b1, 1'b0);
    check("pre_reset_extended", 32'(extended), 32'h1);
    send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("midreset_keyboard", 32'(keyboard), 32'h00);
    check("midreset_extended", 32'(extended), 32'h0);
    check("midreset_valid", 32'(valid), 32'h0);
    check("midreset_frame_err", 32'(frame_err), 32'h0);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cycles(5);
    rst = 1'b1;
    wait_cycles(20);
    snap(); send_frame(8'h29, 1'b0, 1'b1, 1'b0);
    check("post_reset_keyboard", 32'(last_kb), 32'h29);
    check("post_reset_extended", 32'(last_ext), 32'h0);
    check("post_reset_valid", 32'(vcount - v0), 32'd1);

    check("valid_err_exclusive", 32'(both), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
